// File: rtl/gate_bist_ctrl_if.sv
// Bus between gate_bist_ctrl and its host/gate environment.
// master: host side (drives start and the gate readback).
// slave:  BIST controller side.
interface gate_bist_ctrl_if #(
    parameter int unsigned ERR_W = 8
);
    logic             start;
    logic             a_o;
    logic             b_o;
    logic             y0_i;
    logic             y1_i;
    logic             y2_i;
    logic             busy;
    logic             done;
    logic             pass;
    logic [ERR_W-1:0] err_cnt;
    logic [3:0]       fail_vec;
    logic [2:0]       gate_err;

    modport master (
        output start, y0_i, y1_i, y2_i,
        input  a_o, b_o, busy, done, pass, err_cnt, fail_vec, gate_err
    );

    modport slave (
        input  start, y0_i, y1_i, y2_i,
        output a_o, b_o, busy, done, pass, err_cnt, fail_vec, gate_err
    );
endinterface

// File: rtl/gate_bist_ctrl.sv
// Self-test sequencer for the two-input gate block (y0=NAND, y1=NOR, y2=NOT a).
// Walks {a,b} through 00,01,10,11 for LOOPS passes, waits SETTLE_CYCLES after
// each drive, samples y0..y2 and accumulates error count and fault flags.
// Optional: define GATE_BIST_STOP_ON_FAIL_EN to end the test at the first
// mismatching sample.
module gate_bist_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned LOOPS         = 1,
    parameter int unsigned ERR_W         = 8
) (
    input  logic            clk,
    input  logic            reset,
    gate_bist_ctrl_if.slave bus
);

    localparam int unsigned VEC_W  = 2;
    localparam int unsigned NVEC   = 4;
    localparam int unsigned SET_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int unsigned LOOP_W = (LOOPS > 1) ? $clog2(LOOPS) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t            state;
    logic [VEC_W-1:0]  vec_idx;
    logic [LOOP_W-1:0] loop_idx;
    logic [SET_W-1:0]  settle_cnt;
    logic              a_q;
    logic              b_q;
    logic              busy_q;
    logic              done_q;
    logic              pass_q;
    logic [ERR_W-1:0]  err_q;
    logic [NVEC-1:0]   fail_vec_q;
    logic [2:0]        gate_err_q;

    logic [2:0]        obs_c;
    logic [2:0]        exp_c;
    logic [2:0]        diff_c;
    logic              mismatch_c;
    logic [ERR_W-1:0]  err_sat_c;
    logic              last_settle_c;
    logic              last_vec_c;
    logic              last_loop_c;

    // Expected truth table against the currently driven a/b, plus sequencing flags.
    always_comb begin
        obs_c         = {bus.y2_i, bus.y1_i, bus.y0_i};
        exp_c         = {~a_q, ~(a_q | b_q), ~(a_q & b_q)};
        diff_c        = obs_c ^ exp_c;
        mismatch_c    = |diff_c;
        err_sat_c     = (err_q == {ERR_W{1'b1}}) ? err_q : err_q + ERR_W'(1);
        last_settle_c = (settle_cnt == SET_W'(SETTLE_CYCLES - 1));
        last_vec_c    = (vec_idx == VEC_W'(NVEC - 1));
        last_loop_c   = (loop_idx == LOOP_W'(LOOPS - 1));
    end

    // Sequencer state, drive registers and result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            vec_idx    <= '0;
            loop_idx   <= '0;
            settle_cnt <= '0;
            a_q        <= 1'b0;
            b_q        <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            err_q      <= '0;
            fail_vec_q <= '0;
            gate_err_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        err_q      <= '0;
                        fail_vec_q <= '0;
                        gate_err_q <= '0;
                        pass_q     <= 1'b0;
                        vec_idx    <= '0;
                        loop_idx   <= '0;
                        busy_q     <= 1'b1;
                        state      <= S_DRIVE;
                    end
                end

                S_DRIVE: begin
                    a_q        <= vec_idx[1];
                    b_q        <= vec_idx[0];
                    settle_cnt <= '0;
                    state      <= (SETTLE_CYCLES == 0) ? S_SAMPLE : S_SETTLE;
                end

                S_SETTLE: begin
                    if (last_settle_c) begin
                        state <= S_SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt + SET_W'(1);
                    end
                end

                S_SAMPLE: begin
                    if (mismatch_c) begin
                        err_q               <= err_sat_c;
                        fail_vec_q[vec_idx] <= 1'b1;
                        gate_err_q          <= gate_err_q | diff_c;
                    end
`ifdef GATE_BIST_STOP_ON_FAIL_EN
                    if (mismatch_c) begin
                        done_q <= 1'b1;
                        pass_q <= 1'b0;
                        state  <= S_DONE;
                    end else
`endif
                    if (!last_vec_c) begin
                        vec_idx <= vec_idx + VEC_W'(1);
                        state   <= S_DRIVE;
                    end else if (!last_loop_c) begin
                        loop_idx <= loop_idx + LOOP_W'(1);
                        vec_idx  <= '0;
                        state    <= S_DRIVE;
                    end else begin
                        // Final sample's own mismatch must count toward pass.
                        done_q <= 1'b1;
                        pass_q <= (err_q == '0) && !mismatch_c;
                        state  <= S_DONE;
                    end
                end

                S_DONE: begin
                    a_q    <= 1'b0;
                    b_q    <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Outputs are the registers above, driven straight onto the bus.
    assign bus.a_o      = a_q;
    assign bus.b_o      = b_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.pass     = pass_q;
    assign bus.err_cnt  = err_q;
    assign bus.fail_vec = fail_vec_q;
    assign bus.gate_err = gate_err_q;

endmodule

// File: tb/tb_gate_bist_ctrl.sv
// Directed bench for gate_bist_ctrl: four instances cover default, LOOPS=3,
// LOOPS=3/ERR_W=1 and SETTLE_CYCLES=0; a shared gate model injects faults.
module tb_gate_bist_ctrl;

`ifdef GATE_BIST_STOP_ON_FAIL_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;
    int   fault = 0;

    logic start_r [4];

    always #5 clk = ~clk;

    gate_bist_ctrl_if #(.ERR_W(8)) bus0 ();
    gate_bist_ctrl_if #(.ERR_W(8)) bus1 ();
    gate_bist_ctrl_if #(.ERR_W(1)) bus2 ();
    gate_bist_ctrl_if #(.ERR_W(8)) bus3 ();

    gate_bist_ctrl #(.SETTLE_CYCLES(2), .LOOPS(1), .ERR_W(8)) dut0 (.clk(clk), .reset(reset), .bus(bus0.slave));
    gate_bist_ctrl #(.SETTLE_CYCLES(2), .LOOPS(3), .ERR_W(8)) dut1 (.clk(clk), .reset(reset), .bus(bus1.slave));
    gate_bist_ctrl #(.SETTLE_CYCLES(2), .LOOPS(3), .ERR_W(1)) dut2 (.clk(clk), .reset(reset), .bus(bus2.slave));
    gate_bist_ctrl #(.SETTLE_CYCLES(0), .LOOPS(1), .ERR_W(8)) dut3 (.clk(clk), .reset(reset), .bus(bus3.slave));

    // Gate block model with selectable fault: 1 y0 stuck-1, 2 y2 wired to a, 3 y1 stuck-0.
    function automatic logic [2:0] gate_y(input int f, input logic a, input logic b);
        logic [2:0] y;
        y = {~a, ~(a | b), ~(a & b)};
        case (f)
            1:       y[0] = 1'b1;
            2:       y[2] = a;
            3:       y[1] = 1'b0;
            default: ;
        endcase
        return y;
    endfunction

    assign {bus0.y2_i, bus0.y1_i, bus0.y0_i} = gate_y(fault, bus0.a_o, bus0.b_o);
    assign {bus1.y2_i, bus1.y1_i, bus1.y0_i} = gate_y(fault, bus1.a_o, bus1.b_o);
    assign {bus2.y2_i, bus2.y1_i, bus2.y0_i} = gate_y(fault, bus2.a_o, bus2.b_o);
    assign {bus3.y2_i, bus3.y1_i, bus3.y0_i} = gate_y(fault, bus3.a_o, bus3.b_o);
    assign bus0.start = start_r[0];
    assign bus1.start = start_r[1];
    assign bus2.start = start_r[2];
    assign bus3.start = start_r[3];

    logic       busy_w [4];
    logic       done_w [4];
    logic       pass_w [4];
    logic [7:0] err_w  [4];
    logic [3:0] fv_w   [4];
    logic [2:0] ge_w   [4];
    logic [1:0] ab_w   [4];

    assign busy_w[0] = bus0.busy;  assign busy_w[1] = bus1.busy;  assign busy_w[2] = bus2.busy;  assign busy_w[3] = bus3.busy;
    assign done_w[0] = bus0.done;  assign done_w[1] = bus1.done;  assign done_w[2] = bus2.done;  assign done_w[3] = bus3.done;
    assign pass_w[0] = bus0.pass;  assign pass_w[1] = bus1.pass;  assign pass_w[2] = bus2.pass;  assign pass_w[3] = bus3.pass;
    assign err_w[0] = bus0.err_cnt; assign err_w[1] = bus1.err_cnt; assign err_w[2] = 8'(bus2.err_cnt); assign err_w[3] = bus3.err_cnt;
    assign fv_w[0] = bus0.fail_vec; assign fv_w[1] = bus1.fail_vec; assign fv_w[2] = bus2.fail_vec; assign fv_w[3] = bus3.fail_vec;
    assign ge_w[0] = bus0.gate_err; assign ge_w[1] = bus1.gate_err; assign ge_w[2] = bus2.gate_err; assign ge_w[3] = bus3.gate_err;
    assign ab_w[0] = {bus0.a_o, bus0.b_o}; assign ab_w[1] = {bus1.a_o, bus1.b_o};
    assign ab_w[2] = {bus2.a_o, bus2.b_o}; assign ab_w[3] = {bus3.a_o, bus3.b_o};

    logic       busy_log [64];
    logic [1:0] ab_log   [64];
    logic [7:0] err_log  [64];
    int         done_cyc;
    int         n_done;
    logic       pass_at;
    logic [7:0] err_at;
    logic [3:0] fv_at;
    logic [2:0] ge_at;

    // Start DUT d at edge 0, then log cycles 1..ncyc; start re-pulsed in cycles p1/p2.
    task automatic run(input int d, input int ncyc, input int p1, input int p2);
        done_cyc = -1;
        n_done   = 0;
        pass_at  = 1'bx;
        err_at   = 'x;
        fv_at    = 'x;
        ge_at    = 'x;
        @(negedge clk);
        start_r[d] = 1'b1;
        @(posedge clk);
        #1 start_r[d] = 1'b0;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            busy_log[c] = busy_w[d];
            ab_log[c]   = ab_w[d];
            err_log[c]  = err_w[d];
            if (done_w[d] === 1'b1) begin
                n_done++;
                if (done_cyc < 0) begin
                    done_cyc = c;
                    pass_at  = pass_w[d];
                    err_at   = err_w[d];
                    fv_at    = fv_w[d];
                    ge_at    = ge_w[d];
                end
            end
            start_r[d] = (c == p1) || (c == p2);
        end
        start_r[d] = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) start_r[i] = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if (busy_w[0] !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy_w[0]); end
        n_checks++; if (done_w[0] !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b want 0", done_w[0]); end
        n_checks++; if (pass_w[0] !== 1'b0) begin n_fail++; $display("FAIL rst_pass: got %b want 0", pass_w[0]); end
        n_checks++; if (err_w[0] !== 8'd0) begin n_fail++; $display("FAIL rst_err: got %0d want 0", err_w[0]); end
        n_checks++; if (fv_w[0] !== 4'b0000) begin n_fail++; $display("FAIL rst_fail_vec: got %b want 0000", fv_w[0]); end
        n_checks++; if (ge_w[0] !== 3'b000) begin n_fail++; $display("FAIL rst_gate_err: got %b want 000", ge_w[0]); end
        n_checks++; if (ab_w[0] !== 2'b00) begin n_fail++; $display("FAIL rst_ab: got %b want 00", ab_w[0]); end
        n_checks++; if (err_w[2] !== 8'd0) begin n_fail++; $display("FAIL rst_err_w1: got %0d want 0", err_w[2]); end
        reset = 1'b0;
    endtask

    task automatic test_clean();
        logic [1:0] exp_ab;
        fault = 0;
        run(0, 20, 0, 0);
        n_checks++; if (done_cyc !== 17) begin n_fail++; $display("FAIL clean_done_cyc: got %0d want 17", done_cyc); end
        n_checks++; if (n_done !== 1) begin n_fail++; $display("FAIL clean_n_done: got %0d want 1", n_done); end
        n_checks++; if (pass_at !== 1'b1) begin n_fail++; $display("FAIL clean_pass: got %b want 1", pass_at); end
        n_checks++; if (err_at !== 8'd0) begin n_fail++; $display("FAIL clean_err: got %0d want 0", err_at); end
        n_checks++; if (fv_at !== 4'b0000) begin n_fail++; $display("FAIL clean_fail_vec: got %b want 0000", fv_at); end
        n_checks++; if (ge_at !== 3'b000) begin n_fail++; $display("FAIL clean_gate_err: got %b want 000", ge_at); end
        n_checks++; if (pass_w[0] !== 1'b1) begin n_fail++; $display("FAIL clean_pass_held: got %b want 1", pass_w[0]); end
        for (int c = 1; c <= 20; c++) begin
            // 00 cycles 1-5 (reset value then drive), 01 6-9, 10 10-13, 11 14-17, back to 00.
            if (c < 6 || c > 17) exp_ab = 2'b00;
            else if (c < 10)     exp_ab = 2'b01;
            else if (c < 14)     exp_ab = 2'b10;
            else                 exp_ab = 2'b11;
            n_checks++; if (busy_log[c] !== (c <= 17)) begin n_fail++; $display("FAIL clean_busy cyc %0d: got %b want %b", c, busy_log[c], (c <= 17)); end
            n_checks++; if (ab_log[c] !== exp_ab) begin n_fail++; $display("FAIL clean_ab cyc %0d: got %b want %b", c, ab_log[c], exp_ab); end
        end
    endtask

    task automatic test_y0_stuck();
        fault = 1;
        run(0, 20, 0, 0);
        n_checks++; if (done_cyc !== 17) begin n_fail++; $display("FAIL y0_done_cyc: got %0d want 17", done_cyc); end
        n_checks++; if (pass_at !== 1'b0) begin n_fail++; $display("FAIL y0_pass: got %b want 0", pass_at); end
        n_checks++; if (err_at !== 8'd1) begin n_fail++; $display("FAIL y0_err: got %0d want 1", err_at); end
        n_checks++; if (fv_at !== 4'b1000) begin n_fail++; $display("FAIL y0_fail_vec: got %b want 1000", fv_at); end
        n_checks++; if (ge_at !== 3'b001) begin n_fail++; $display("FAIL y0_gate_err: got %b want 001", ge_at); end
        n_checks++; if (err_w[0] !== 8'd1) begin n_fail++; $display("FAIL y0_err_held: got %0d want 1", err_w[0]); end
    endtask

    task automatic test_y2_wired_a();
        int         exp_cyc;
        logic [7:0] exp_err;
        logic [3:0] exp_fv;
        exp_cyc = STOP ? 5 : 17;
        exp_err = STOP ? 8'd1 : 8'd4;
        exp_fv  = STOP ? 4'b0001 : 4'b1111;
        fault = 2;
        run(0, 20, 0, 0);
        n_checks++; if (done_cyc !== exp_cyc) begin n_fail++; $display("FAIL y2_done_cyc: got %0d want %0d", done_cyc, exp_cyc); end
        n_checks++; if (n_done !== 1) begin n_fail++; $display("FAIL y2_n_done: got %0d want 1", n_done); end
        n_checks++; if (pass_at !== 1'b0) begin n_fail++; $display("FAIL y2_pass: got %b want 0", pass_at); end
        n_checks++; if (err_at !== exp_err) begin n_fail++; $display("FAIL y2_err: got %0d want %0d", err_at, exp_err); end
        n_checks++; if (fv_at !== exp_fv) begin n_fail++; $display("FAIL y2_fail_vec: got %b want %b", fv_at, exp_fv); end
        n_checks++; if (ge_at !== 3'b100) begin n_fail++; $display("FAIL y2_gate_err: got %b want 100", ge_at); end
        // First SAMPLE is cycle 4; the count shows up in cycle 5.
        n_checks++; if (err_log[4] !== 8'd0) begin n_fail++; $display("FAIL y2_err_cyc4: got %0d want 0", err_log[4]); end
        n_checks++; if (err_log[5] !== 8'd1) begin n_fail++; $display("FAIL y2_err_cyc5: got %0d want 1", err_log[5]); end
    endtask

    task automatic test_y1_stuck_loops();
        int         exp_cyc;
        logic [7:0] exp_err;
        exp_cyc = STOP ? 5 : 49;
        exp_err = STOP ? 8'd1 : 8'd3;
        fault = 3;
        run(1, 55, 0, 0);
        n_checks++; if (done_cyc !== exp_cyc) begin n_fail++; $display("FAIL l3_done_cyc: got %0d want %0d", done_cyc, exp_cyc); end
        n_checks++; if (err_at !== exp_err) begin n_fail++; $display("FAIL l3_err: got %0d want %0d", err_at, exp_err); end
        n_checks++; if (fv_at !== 4'b0001) begin n_fail++; $display("FAIL l3_fail_vec: got %b want 0001", fv_at); end
        n_checks++; if (ge_at !== 3'b010) begin n_fail++; $display("FAIL l3_gate_err: got %b want 010", ge_at); end
        n_checks++; if (pass_at !== 1'b0) begin n_fail++; $display("FAIL l3_pass: got %b want 0", pass_at); end
        run(2, 55, 0, 0);
        n_checks++; if (done_cyc !== exp_cyc) begin n_fail++; $display("FAIL sat_done_cyc: got %0d want %0d", done_cyc, exp_cyc); end
        n_checks++; if (err_at !== 8'd1) begin n_fail++; $display("FAIL sat_err: got %0d want 1", err_at); end
        n_checks++; if (fv_at !== 4'b0001) begin n_fail++; $display("FAIL sat_fail_vec: got %b want 0001", fv_at); end
    endtask

    task automatic test_reset_mid();
        int dones;
        fault = 0;
        dones = 0;
        @(negedge clk);
        start_r[0] = 1'b1;
        @(posedge clk);
        #1 start_r[0] = 1'b0;
        for (int c = 1; c <= 7; c++) @(negedge clk);
        n_checks++; if (ab_w[0] !== 2'b01) begin n_fail++; $display("FAIL mid_ab_before: got %b want 01", ab_w[0]); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_checks++; if (busy_w[0] !== 1'b0) begin n_fail++; $display("FAIL mid_busy: got %b want 0", busy_w[0]); end
        n_checks++; if (ab_w[0] !== 2'b00) begin n_fail++; $display("FAIL mid_ab: got %b want 00", ab_w[0]); end
        n_checks++; if (done_w[0] !== 1'b0) begin n_fail++; $display("FAIL mid_done: got %b want 0", done_w[0]); end
        n_checks++; if (pass_w[0] !== 1'b0) begin n_fail++; $display("FAIL mid_pass: got %b want 0", pass_w[0]); end
        for (int c = 9; c <= 25; c++) begin
            @(negedge clk);
            if (done_w[0] === 1'b1 || busy_w[0] === 1'b1) dones++;
        end
        n_checks++; if (dones !== 0) begin n_fail++; $display("FAIL mid_no_activity: got %0d want 0", dones); end
        run(0, 20, 0, 0);
        n_checks++; if (done_cyc !== 17) begin n_fail++; $display("FAIL mid_rerun_cyc: got %0d want 17", done_cyc); end
        n_checks++; if (pass_at !== 1'b1) begin n_fail++; $display("FAIL mid_rerun_pass: got %b want 1", pass_at); end
    endtask

    task automatic test_back_to_back();
        int first;
        int second;
        fault = 0;
        run(0, 22, 3, 10);
        n_checks++; if (n_done !== 1) begin n_fail++; $display("FAIL busy_start_n_done: got %0d want 1", n_done); end
        n_checks++; if (done_cyc !== 17) begin n_fail++; $display("FAIL busy_start_cyc: got %0d want 17", done_cyc); end
        // start held high: second run accepted in IDLE cycle 18, done in cycle 35.
        first = -1;
        second = -1;
        @(negedge clk);
        start_r[0] = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            busy_log[c] = busy_w[0];
            if (done_w[0] === 1'b1) begin
                if (first < 0) first = c;
                else if (second < 0) second = c;
            end
            if (c == 35) start_r[0] = 1'b0;
        end
        n_checks++; if (first !== 17) begin n_fail++; $display("FAIL hold_first: got %0d want 17", first); end
        n_checks++; if (second !== 35) begin n_fail++; $display("FAIL hold_second: got %0d want 35", second); end
        n_checks++; if (busy_log[18] !== 1'b0) begin n_fail++; $display("FAIL hold_idle_gap: got %b want 0", busy_log[18]); end
        n_checks++; if (busy_log[19] !== 1'b1) begin n_fail++; $display("FAIL hold_rebusy: got %b want 1", busy_log[19]); end
        n_checks++; if (busy_log[37] !== 1'b0) begin n_fail++; $display("FAIL hold_released: got %b want 0", busy_log[37]); end
    endtask

    task automatic test_settle0();
        fault = 0;
        run(3, 12, 0, 0);
        n_checks++; if (done_cyc !== 9) begin n_fail++; $display("FAIL s0_done_cyc: got %0d want 9", done_cyc); end
        n_checks++; if (n_done !== 1) begin n_fail++; $display("FAIL s0_n_done: got %0d want 1", n_done); end
        n_checks++; if (pass_at !== 1'b1) begin n_fail++; $display("FAIL s0_pass: got %b want 1", pass_at); end
        n_checks++; if (ab_log[8] !== 2'b11) begin n_fail++; $display("FAIL s0_ab_last: got %b want 11", ab_log[8]); end
    endtask

    initial begin
        test_reset();
        test_clean();
        test_y0_stuck();
        test_y2_wired_a();
        test_y1_stuck_loops();
        test_reset_mid();
        test_back_to_back();
        test_settle0();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
